// File: rtl/fp_accumulator_pkg.sv
// Shared field layout, saturation constant and FSM encoding for fp_accumulator
// and its single-precision adder.
package fp_accumulator_pkg;

    localparam int SIGN_BIT = 31;
    localparam int EXP_MSB  = 30;
    localparam int EXP_LSB  = 23;
    localparam int FRAC_W   = 23;

    localparam logic [7:0]  EXP_MAX       = 8'hFF;
    localparam logic [30:0] FP_MAX_FINITE = {8'hFE, 23'h7FFFFF};

    typedef enum logic [1:0] {
        S_EMPTY = 2'd0,
        S_ACC   = 2'd1,
        S_OUT   = 2'd2
    } state_t;

    function automatic logic [7:0] fp_exp(input logic [31:0] x);
        return x[EXP_MSB:EXP_LSB];
    endfunction

    function automatic logic fp_is_zero(input logic [31:0] x);
        return (x[EXP_MSB:0] == 31'd0);
    endfunction

    function automatic logic [31:0] fp_saturate(input logic sign);
        return {sign, FP_MAX_FINITE};
    endfunction

endpackage

// File: rtl/fp_accumulator_adder.sv
// fp_adder: combinational single-precision adder with truncating alignment and
// normalisation; overflow produces a signed infinity, exact cancellation gives +0.
import fp_accumulator_pkg::*;

module fp_adder (
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] sum
);

    logic        a_big;
    logic [31:0] x;
    logic [31:0] y;
    logic [7:0]  ex;
    logic [7:0]  ey;
    logic [7:0]  ex_eff;
    logic [7:0]  ey_eff;
    logic [23:0] mx;
    logic [23:0] my;
    logic [7:0]  diff;
    logic [23:0] my_sh;
    logic [24:0] raw;
    logic [4:0]  lz;
    logic        found;
    logic [8:0]  e_inc;
    logic [7:0]  shift_dn;

    always_comb begin
        a_big = (a[EXP_MSB:0] >= b[EXP_MSB:0]);
        x     = a_big ? a : b;
        y     = a_big ? b : a;
        ex    = fp_exp(x);
        ey    = fp_exp(y);
        // Subnormals share the exponent of the smallest normal, without hidden bit.
        ex_eff = (ex == 8'd0) ? 8'd1 : ex;
        ey_eff = (ey == 8'd0) ? 8'd1 : ey;
        mx     = {(ex != 8'd0), x[FRAC_W-1:0]};
        my     = {(ey != 8'd0), y[FRAC_W-1:0]};
        diff   = ex_eff - ey_eff;
        my_sh  = my >> diff;

        if (x[SIGN_BIT] == y[SIGN_BIT]) begin
            raw = {1'b0, mx} + {1'b0, my_sh};
        end else begin
            raw = {1'b0, mx} - {1'b0, my_sh};
        end

        lz    = 5'd0;
        found = 1'b0;
        for (int i = 23; i >= 0; i--) begin
            if (!found && raw[i]) begin
                lz    = 5'(23 - i);
                found = 1'b1;
            end
        end

        e_inc    = {1'b0, ex_eff} + 9'd1;
        shift_dn = ex_eff - 8'd1;
        sum      = 32'd0;

        if (ex == EXP_MAX) begin
            sum = x;
        end else if (raw == 25'd0) begin
            sum = 32'd0;
        end else if (raw[24]) begin
            if (e_inc >= 9'd255) begin
                sum = {x[SIGN_BIT], EXP_MAX, 23'd0};
            end else begin
                sum = {x[SIGN_BIT], e_inc[7:0], raw[23:1]};
            end
        end else if ({3'b000, lz} < ex_eff) begin
            sum = {x[SIGN_BIT], ex_eff - {3'b000, lz}, 23'(raw[22:0] << lz)};
        end else begin
            sum = {x[SIGN_BIT], 8'd0, 23'(raw[22:0] << shift_dn)};
        end
    end

endmodule

// File: rtl/fp_accumulator.sv
// Streaming single-precision frame accumulator around one fp_adder.
// Optional macro FP_ACC_OVF_EN: saturate to largest finite and flag sticky overflow.
import fp_accumulator_pkg::*;

module fp_accumulator #(
    parameter int MAX_LEN = 256,
    parameter int CNT_W   = 9
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_data,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_sum,
    output logic [CNT_W-1:0] out_count,
    output logic             out_ovf
);

    // state   | meaning
    // S_EMPTY | waiting for first word of a frame, acc gets loaded directly
    // S_ACC   | mid-frame, each word is added into acc
    // S_OUT   | frame result held until the consumer takes it

    state_t           state_q, state_d;
    logic [31:0]      acc_q, acc_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [CNT_W-1:0] count_inc;
    logic [31:0]      add_sum;
    logic [31:0]      cand;
    logic             in_xfer;

    fp_adder u_fp_adder (
        .a   (acc_q),
        .b   (in_data),
        .sum (add_sum)
    );

`ifdef FP_ACC_OVF_EN
    logic ovf_q, ovf_d;
`endif

    assign in_ready  = (state_q != S_OUT);
    assign out_valid = (state_q == S_OUT);
    assign out_sum   = acc_q;
    assign out_count = count_q;
    assign in_xfer   = in_valid && in_ready;
    assign count_inc = count_q + 1'b1;

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        count_d = count_q;
        cand    = acc_q;
`ifdef FP_ACC_OVF_EN
        ovf_d   = ovf_q;
`endif

        case (state_q)
            S_EMPTY: begin
                if (in_xfer) begin
                    cand    = in_data;
                    count_d = CNT_W'(1);
                    state_d = (in_last || MAX_LEN == 1) ? S_OUT : S_ACC;
                end
            end
            S_ACC: begin
                if (in_xfer) begin
                    count_d = count_inc;
                    // Zero operands bypass the adder so its zero handling never matters.
                    if (fp_is_zero(in_data)) begin
                        cand = acc_q;
                    end else if (fp_is_zero(acc_q)) begin
                        cand = in_data;
                    end else begin
                        cand = add_sum;
                    end
                    state_d = (in_last || count_inc == CNT_W'(MAX_LEN)) ? S_OUT : S_ACC;
                end
            end
            S_OUT: begin
                if (out_ready) begin
                    state_d = S_EMPTY;
                    count_d = '0;
`ifdef FP_ACC_OVF_EN
                    ovf_d   = 1'b0;
`endif
                end
            end
            default: begin
                state_d = S_EMPTY;
            end
        endcase

        if (in_xfer) begin
`ifdef FP_ACC_OVF_EN
            if (fp_exp(cand) == EXP_MAX || fp_exp(in_data) == EXP_MAX) begin
                acc_d = fp_saturate(cand[SIGN_BIT]);
                ovf_d = 1'b1;
            end else begin
                acc_d = cand;
            end
`else
            acc_d = cand;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_EMPTY;
            acc_q   <= 32'd0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            count_q <= count_d;
        end
    end

`ifdef FP_ACC_OVF_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            ovf_q <= 1'b0;
        end else begin
            ovf_q <= ovf_d;
        end
    end

    assign out_ovf = ovf_q;
`else
    assign out_ovf = 1'b0;
`endif

endmodule

// File: tb/tb_fp_accumulator.sv
// Directed bench for fp_accumulator: a default-size instance plus a MAX_LEN=4 instance
// sharing the same input stimulus.
module tb_fp_accumulator;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic [31:0] in_data;
    logic        in_last;
    logic        out_ready;

    logic        in_ready;
    logic        out_valid;
    logic [31:0] out_sum;
    logic [8:0]  out_count;
    logic        out_ovf;

    logic        d4_in_ready;
    logic        d4_out_valid;
    logic [31:0] d4_out_sum;
    logic [2:0]  d4_out_count;
    logic        d4_out_ovf;

    int total = 0;
    int bad   = 0;

    logic [31:0] held_sum;

    always #5 clk = ~clk;

    fp_accumulator dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_count (out_count),
        .out_ovf   (out_ovf)
    );

    fp_accumulator #(.MAX_LEN(4), .CNT_W(3)) dut4 (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (d4_in_ready),
        .in_data   (in_data),
        .in_last   (in_last),
        .out_valid (d4_out_valid),
        .out_ready (out_ready),
        .out_sum   (d4_out_sum),
        .out_count (d4_out_count),
        .out_ovf   (d4_out_ovf)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        total++;
        assert (obs === exp_v) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [31:0] d, input logic last);
        in_valid = 1'b1;
        in_data  = d;
        in_last  = last;
        tick();
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic accept();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    task automatic check_result(input string tag, input logic [31:0] s, input logic [31:0] c,
                                input logic ovf);
        check({tag, "_valid"}, 32'(out_valid), 32'd1);
        check({tag, "_sum"},   out_sum, s);
        check({tag, "_count"}, 32'(out_count), c);
        check({tag, "_ovf"},   32'(out_ovf), 32'(ovf));
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = 32'd0;
        in_last   = 1'b0;
        out_ready = 1'b0;
        tick();
        tick();
        rst = 1'b0;

        check("rst_valid", 32'(out_valid), 32'd0);
        check("rst_ready", 32'(in_ready), 32'd1);
        check("rst_sum",   out_sum, 32'd0);
        check("rst_count", 32'(out_count), 32'd0);
        check("rst_ovf",   32'(out_ovf), 32'd0);

        // single word frame
        send(32'h41200000, 1'b1);
        check_result("single", 32'h41200000, 32'd1, 1'b0);
        check("single_in_ready", 32'(in_ready), 32'd0);
        accept();
        check("single_drained", 32'(out_valid), 32'd0);

        // 1 + 2 + 4, back to back
        send(32'h3F800000, 1'b0);
        send(32'h40000000, 1'b0);
        check("three_mid", 32'(out_valid), 32'd0);
        send(32'h40800000, 1'b1);
        check_result("three", 32'h40E00000, 32'd3, 1'b0);
        accept();

        // exact cancellation then a fresh frame
        send(32'hC6193AAE, 1'b0);
        send(32'h46193AAE, 1'b1);
        check_result("cancel", 32'h00000000, 32'd2, 1'b0);
        accept();
        send(32'h40000000, 1'b0);
        send(32'h3F800000, 1'b1);
        check_result("after_cancel", 32'h40400000, 32'd2, 1'b0);
        accept();

        // zero first word, reload, then -0 ignored
        send(32'h00000000, 1'b0);
        send(32'h40000000, 1'b0);
        send(32'h80000000, 1'b1);
        check_result("zero_reload", 32'h40000000, 32'd3, 1'b0);
        accept();

        // backpressure on result with input pending
        send(32'h3F800000, 1'b1);
        held_sum  = out_sum;
        in_valid  = 1'b1;
        in_data   = 32'h40000000;
        in_last   = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("bp_in_ready", 32'(in_ready), 32'd0);
            check("bp_valid", 32'(out_valid), 32'd1);
            check("bp_sum", out_sum, 32'h3F800000);
        end
        check("bp_sum_held", out_sum, held_sum);
        accept();
        in_valid = 1'b0;
        in_last  = 1'b0;
        check("bp_no_input_on_xfer", 32'(out_valid), 32'd0);
        check("bp_count_cleared", 32'(out_count), 32'd0);

        // reset mid-frame discards partial sum
        send(32'h40000000, 1'b0);
        send(32'h40400000, 1'b0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("midrst_valid", 32'(out_valid), 32'd0);
        check("midrst_ready", 32'(in_ready), 32'd1);
        check("midrst_sum",   out_sum, 32'd0);
        check("midrst_count", 32'(out_count), 32'd0);
        check("midrst_ovf",   32'(out_ovf), 32'd0);
        send(32'h3F800000, 1'b1);
        check_result("post_rst", 32'h3F800000, 32'd1, 1'b0);
        accept();

        // MAX_LEN=4 forced frame end; default instance keeps accumulating
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int i = 0; i < 4; i++) send(32'h3F800000, 1'b0);
        check("max4_valid", 32'(d4_out_valid), 32'd1);
        check("max4_sum",   d4_out_sum, 32'h40800000);
        check("max4_count", 32'(d4_out_count), 32'd4);
        check("max4_ready", 32'(d4_in_ready), 32'd0);
        check("max4_big_busy", 32'(out_valid), 32'd0);
        accept();
        check("max4_drained", 32'(d4_out_valid), 32'd0);
        send(32'h3F800000, 1'b0);
        send(32'h3F800000, 1'b1);
        check("max4_second_sum",   d4_out_sum, 32'h40000000);
        check("max4_second_count", 32'(d4_out_count), 32'd2);
        check_result("six_ones", 32'h40C00000, 32'd6, 1'b0);
        accept();

        // in_last exactly at the MAX_LEN boundary ends the frame once
        for (int i = 0; i < 3; i++) send(32'h3F800000, 1'b0);
        send(32'h3F800000, 1'b1);
        check("bnd_count", 32'(d4_out_count), 32'd4);
        check("bnd_sum",   d4_out_sum, 32'h40800000);
        accept();
        check("bnd_once_valid", 32'(d4_out_valid), 32'd0);
        check("bnd_once_ready", 32'(d4_in_ready), 32'd1);

        // overflow
        send(32'h7F7FFFFF, 1'b0);
        send(32'h7F7FFFFF, 1'b1);
`ifdef FP_ACC_OVF_EN
        check_result("ovf", 32'h7F7FFFFF, 32'd2, 1'b1);
`else
        check_result("ovf", 32'h7F800000, 32'd2, 1'b0);
`endif
        accept();
        send(32'h3F800000, 1'b1);
        check_result("ovf_cleared", 32'h3F800000, 32'd1, 1'b0);
        accept();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
